gpr_scoreboard: RTL

Tracks in-flight GPR writes between issue (Decode) and the GPR write port driven by the writeback stage. Per register, it counts outstanding writers. It stalls issue on RAW hazards and on per-register counter saturation. A small FSM gates issue during start-up and pipeline drain (halt/debug), and reports when no writes remain outstanding.

---
 rtl/gpr_scoreboard_pkg.sv | 20 ++
 rtl/gpr_scoreboard_sb_reg_counter.sv | 58 +++++
 rtl/gpr_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gpr_scoreboard_pkg.sv
// Shared constants and types for the GPR write scoreboard.
//   NUM_GPR / GPR_ADDR_W : architectural register file geometry
//   RA_REG               : link register written by calls (Decode maps isCall to it)
//   SB_MAX_INFLIGHT      : outstanding writes per register (issue->WB depth)
//   sb_state_t           : scoreboard control FSM states
package gpr_scoreboard_pkg;

  localparam int NUM_GPR         = 16;
  localparam int GPR_ADDR_W      = 4;
  localparam logic [GPR_ADDR_W-1:0] RA_REG = 4'hF;
  localparam int SB_MAX_INFLIGHT = 3;
  localparam int SB_CNT_W        = 2;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_RUN   = 2'd1,
    SB_DRAIN = 2'd2
  } sb_state_t;

endpackage

// File: rtl/gpr_scoreboard_sb_reg_counter.sv
// Per-register outstanding-writer counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : force the count to zero (scoreboard idle / stopped)
//   en_i         : tracking enabled (RUN or DRAIN)
//   inc_i        : accepted issue targets this register
//   dec_i        : retire on the GPR write port targets this register
//   cnt_o        : current outstanding-writer count
//   uflow_o      : this cycle's retire found the count already zero
module gpr_scoreboard_sb_reg_counter #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             uflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    uflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i) begin
      unique case ({inc_i, dec_i})
        2'b10: begin
          // Issue stall keeps us below saturation; the guard only protects
          // against a misbehaving upstream.
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
        2'b01: begin
          if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
          else                   uflow_o = 1'b1;
        end
        default: cnt_d = cnt_q;  // idle, or issue and retire cancel out
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= CNT_ZERO;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gpr_scoreboard.sv
// GPR write scoreboard: counts in-flight writers per register between Decode
// issue and the writeback GPR write port, stalls issue on RAW hazards and on
// per-register counter saturation, and gates issue during start-up / drain.
//   clk, rst             : clock, asynchronous active-high reset
//   Start                : core run enable; low forces IDLE and clears tracking
//   issue_*              : instruction presented by Decode (rd, rs1/rs2 + use flags)
//   rf_wr_en/rf_wr_addr  : retire strobe from the WB GPR write port
//   drain_req            : halt/debug drain request (level)
//   stall, issue_accept  : issue handshake back to Decode
//   pending_mask         : bit i set while register i has outstanding writers
//   drained              : draining and nothing outstanding
//   err_underflow        : sticky, retire seen for a register with no writer
module gpr_scoreboard
  import gpr_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_GPR,
  parameter int ADDR_W       = GPR_ADDR_W,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int CNT_W        = SB_CNT_W,
  parameter bit BYPASS_WB    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Start,
  input  logic                issue_valid,
  input  logic                issue_isWb,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_use_rs1,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic                issue_use_rs2,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                rf_wr_en,
  input  logic [ADDR_W-1:0]   rf_wr_addr,
  input  logic                drain_req,
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                drained,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_state_t state_q;
  sb_state_t state_d;
  logic      err_q;
  logic      err_d;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] uflow;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] src_busy;
  logic [NUM_REGS-1:0] rd_full;

  logic track_en;
  logic track_clr;
  logic hazard;

  assign track_en  = (state_q == SB_RUN) || (state_q == SB_DRAIN);
  // IDLE holds counters at zero, so retires arriving there are simply dropped.
  assign track_clr = !Start || (state_q == SB_IDLE);

  // Per-register hazard terms. A final retire this cycle hides a RAW hazard
  // only when the register file forwards the write to same-cycle reads.
  // A retire to a saturated rd always frees a slot, so it lifts the WAW limit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      src_busy[i] = (cnt[i] != '0) &&
                    !(BYPASS_WB && (cnt[i] == CNT_ONE) &&
                      rf_wr_en && (rf_wr_addr == ADDR_W'(i)));
      rd_full[i]  = (cnt[i] == CNT_MAX) &&
                    !(rf_wr_en && (rf_wr_addr == ADDR_W'(i)));
      inc[i]      = issue_accept && issue_isWb && (issue_rd == ADDR_W'(i));
      dec[i]      = rf_wr_en && (rf_wr_addr == ADDR_W'(i));
    end
  end

  assign hazard = (issue_use_rs1 && src_busy[issue_rs1]) ||
                  (issue_use_rs2 && src_busy[issue_rs2]) ||
                  (issue_isWb    && rd_full[issue_rd]);

  assign stall        = (state_q != SB_RUN) || (issue_valid && hazard);
  assign issue_accept = issue_valid && !stall;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_cnt
      gpr_scoreboard_sb_reg_counter #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
      ) u_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (track_clr),
        .en_i    (track_en),
        .inc_i   (inc[g]),
        .dec_i   (dec[g]),
        .cnt_o   (cnt[g]),
        .uflow_o (uflow[g])
      );
      assign pending_mask[g] = (cnt[g] != '0);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    err_d   = err_q | (|uflow);
    if (!Start) begin
      state_d = SB_IDLE;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        SB_IDLE:  state_d = SB_RUN;
        SB_RUN:   if (drain_req)  state_d = SB_DRAIN;
        SB_DRAIN: if (!drain_req) state_d = SB_RUN;
        default:  state_d = SB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SB_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign drained       = (state_q == SB_DRAIN) && !(|pending_mask);
  assign err_underflow = err_q;

endmodule
